// File: rtl/encoder_8x3_if.sv
// Bus between a one-hot requester and the registered 8-to-3 encoder.
// The requester drives D; the encoder returns the index {A,B,C} plus V and ERR.
interface encoder_8x3_if;
    logic [7:0] D;
    logic       A;
    logic       B;
    logic       C;
    logic       V;
    logic       ERR;

    modport master (output D, input A, B, C, V, ERR);
    modport slave  (input D, output A, B, C, V, ERR);
endinterface

// File: rtl/encoder_8x3.sv
// Registered 8-to-3 priority encoder: highest set bit of D wins.
// V flags any request; ERR flags a multi-hot request. One-cycle latency.
module encoder_8x3 (
    input  logic          clk,
    input  logic          rst,
    encoder_8x3_if.slave  bus
);
    logic [2:0] idx;
    logic       any;
    logic       multi;
    logic [2:0] idx_q;
    logic       v_q;
    logic       err_q;

    // Ascending scan, so the last hit (highest index) overrides lower ones.
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.D[i]) idx = 3'(i);
        end
    end

    assign any   = |bus.D;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(bus.D & (bus.D - 8'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= 3'd0;
            v_q   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            idx_q <= idx;
            v_q   <= any;
            err_q <= multi;
        end
    end

    assign bus.A   = idx_q[2];
    assign bus.B   = idx_q[1];
    assign bus.C   = idx_q[0];
    assign bus.V   = v_q;
    assign bus.ERR = err_q;
endmodule

// File: tb/tb_encoder_8x3.sv
// Directed bench for encoder_8x3; expected {A,B,C,V,ERR} values are hand-computed.
module tb_encoder_8x3;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    encoder_8x3_if bus ();

    encoder_8x3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {bus.A, bus.B, bus.C, bus.V, bus.ERR};
    endfunction

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got {A,B,C,V,ERR}=%b expected %b", tag, got, exp);
    endtask

    // Drive D away from the edge, then sample just after the capturing edge.
    task automatic step(input logic [7:0] d);
        @(negedge clk);
        bus.D = d;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_d   [9] = '{8'h00, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [4:0] sweep_exp [9] = '{5'b000_0_0, 5'b111_1_0, 5'b110_1_0, 5'b101_1_0, 5'b100_1_0,
                                  5'b011_1_0, 5'b010_1_0, 5'b001_1_0, 5'b000_1_0};

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        bus.D  = 8'hFF;

        // Reset holds outputs low across clock edges.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", outs(), 5'b000_0_0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_after_reset", outs(), 5'b111_1_1);

        for (int i = 0; i < 9; i++) begin
            step(sweep_d[i]);
            chk($sformatf("onehot_%02h", sweep_d[i]), outs(), sweep_exp[i]);
        end

        step(8'b0101_0001);
        chk("prio_51", outs(), 5'b110_1_1);
        step(8'b0000_0011);
        chk("prio_03", outs(), 5'b001_1_1);
        step(8'b0010_0110);
        chk("prio_26", outs(), 5'b101_1_1);
        step(8'b1000_0001);
        chk("prio_81", outs(), 5'b111_1_1);

        step(8'h00);
        chk("zero", outs(), 5'b000_0_0);
        step(8'h01);
        chk("bit0", outs(), 5'b000_1_0);

        // Back-to-back tracking with one-cycle lag.
        step(8'h80);
        chk("b2b_80", outs(), 5'b111_1_0);
        step(8'h01);
        chk("b2b_01", outs(), 5'b000_1_0);
        step(8'h00);
        chk("b2b_00", outs(), 5'b000_0_0);

        // Asynchronous reset mid-cycle, well before the next edge.
        step(8'h20);
        chk("pre_async", outs(), 5'b101_1_0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", outs(), 5'b000_0_0);
        @(posedge clk);
        #1;
        chk("async_reset_hold", outs(), 5'b000_0_0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_async", outs(), 5'b101_1_0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
